sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Multi-cycle SRAM access sequencer shared by two requesters: the instruction-fetch port (IF) and the data-memory port (DM).
- Grants one request at a time and drives the 32-bit asynchronous SRAM pins with registered, glitch-free timing.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the CPU pipeline's fetch/memory stages and one SRAM bank. Upstream address decode selects the bank, so base and ext each get one instance.

Parameters:
- WAIT_CYCLES, 1: read oe_n-low length minus one, and write we_n-low pulse length, in clk cycles; legal range 1..7.
- ADDR_LSB, 2: lowest byte-address bit mapped to sram_addr[0].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- if_req  input  1  fetch request level; held until if_ack.
- if_addr  input  32  fetch byte address.
- if_ack  output  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  output  32  registered fetch data.
- dm_req  input  1  data request level; held until dm_ack.
- dm_we  input  1  1 = write, 0 = read.
- dm_be_n  input  4  active-low byte enables (writes only).
- dm_addr  input  32  data byte address.
- dm_wdata  input  32  write data.
- dm_ack  output  1  one-cycle pulse: data access done.
- dm_rdata  output  32  registered read data.
- sram_data  inout  32  SRAM data bus.
- sram_addr  output  20  word address = granted addr[ADDR_LSB+19:ADDR_LSB].
- sram_be_n  output  4  byte enables; 4'b0000 for reads, dm_be_n for writes.
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, immediate):
  - State IDLE; last_grant = IF.
  - ce_n = oe_n = we_n = 1, be_n = 4'hF, sram_addr = 0.
  - Bus driver off (hi-Z); acks 0; if_rdata and dm_rdata = 0.
  - An access in flight is abandoned with no ack. Requesters re-present after reset.
- All SRAM pin outputs and acks are registered. sram_data is driven only in states WR_SETUP, WR_PULSE and WR_HOLD.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 3-bit wait counter is loaded on entry to RD or WR_PULSE.
- IDLE arbitration, evaluated each edge:
  - No requests: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that is not last_grant (round-robin), then update last_grant.
  - Latch address, we, be_n and wdata into internal registers at the grant edge. Inputs are don't-care afterwards.
- Read path (IF is always read; DM when dm_we = 0):
  - IDLE -> RD: ce_n = 0, oe_n = 0.
  - Stay in RD for WAIT_CYCLES+1 cycles.
  - On the last RD edge, capture sram_data into the granted port's rdata and go to DONE; ce_n and oe_n return to 1.
- Write path (dm_we = 1):
  - WR_SETUP (1 cycle): ce_n = 0, we_n = 1, data driven.
  - WR_PULSE (WAIT_CYCLES cycles): we_n = 0.
  - WR_HOLD (1 cycle): we_n = 1, data still driven, ce_n = 0.
  - Then DONE. The other port's rdata is unchanged.
- DONE (1 cycle): granted ack = 1, all strobes inactive. Next state is IDLE unconditionally.
- Ack timing, where edge E0 is the IDLE edge that grants:
  - Read ack is high in cycle WAIT_CYCLES+2 after E0 (3 with default).
  - Write ack is high in cycle WAIT_CYCLES+3 after E0 (4 with default).
- Requester contract:
  - Deassert req, or change to a new request, at the edge that samples ack high.
  - A req still high in the following IDLE cycle is a new request.
- Minimum spacing: one IDLE cycle between accesses, so back-to-back throughput is one access per WAIT_CYCLES+3 cycles (reads).
- Ungranted requester: its req stays pending, and it receives no ack until served. No starvation: with both ports continuously requesting, grants strictly alternate.
- Simultaneous reset and ack: reset wins; ack = 0.

Test Plan:
- Reset held 0 with if_req = 1 -> all strobes 1, be_n = F, sram_data hi-Z, acks 0. Release -> IF granted, ce_n/oe_n low 2 cycles, if_ack in cycle 3.
- IF read 0x80000010, SRAM model word 4 = 0x12345678 -> sram_addr = 0x00004, if_rdata = 0x12345678 when if_ack = 1. dm_rdata unchanged.
- DM write 0x80000020, data 0xDEADBEEF, be_n = 4'b1100 -> setup 1, we_n low 1, hold 1. Model word 8 bytes [15:0] = 0xBEEF, upper bytes untouched. dm_ack in cycle 4.
- Both reqs held high for 4 accesses after reset -> grant order DM, IF, DM, IF. Each ack is exactly one cycle; no ack is ever given to a non-granted port.
- WAIT_CYCLES = 3, DM read -> oe_n low 4 cycles, dm_ack in cycle 5. Write then read back at the same address returns the written value.
- rst pulsed low during WR_PULSE -> we_n = 1 and the bus goes hi-Z asynchronously, with no dm_ack. After release, the re-presented write completes normally.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin access sequencer sharing one 32-bit asynchronous
//            SRAM bank between the instruction-fetch (IF) port and the
//            data-memory (DM) port. All SRAM pins and acks are registered.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,  // read oe_n-low length minus one / write pulse length, 1..7
  parameter int ADDR_LSB    = 2   // byte-address bit that lands on sram_addr[0]
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active low

  // instruction-fetch port (read only)
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,

  // data-memory port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be_n,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,

  // asynchronous SRAM pins
  inout  wire  [31:0] sram_data,
  output logic [19:0] sram_addr,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Wait-counter reload values. A read stays in RD for WAIT_CYCLES+1 cycles,
  // a write keeps we_n low for WAIT_CYCLES cycles; both exit when the
  // counter reads zero, so the reload is one less than the residency.
  localparam logic [2:0] c_rd_cnt    = 3'(WAIT_CYCLES);
  localparam logic [2:0] c_pulse_cnt = 3'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_gnt_dm;     // 1 = DM owns the current access, 0 = IF
  logic        r_last_dm;    // last_grant: 1 = DM, 0 = IF
  logic [31:0] r_wdata;      // write data latched at the grant edge
  logic        r_drive;      // registered output enable of the data bus

  logic        w_any_req;
  logic        w_grant_dm;
  logic        w_is_write;
  logic [31:0] w_addr;
  logic        w_unused_addr;

  // The bus is driven only from WR_SETUP through WR_HOLD; r_drive is a flop,
  // so the enable cannot glitch and reset releases the bus immediately.
  assign sram_data = r_drive ? r_wdata : 32'bz;

  // Arbitration: a lone request wins; with both pending, the port that was
  // not granted last time wins, so two continuous requesters alternate.
  always_comb begin
    w_any_req  = if_req | dm_req;
    w_grant_dm = dm_req & (~if_req | ~r_last_dm);
    w_addr     = w_grant_dm ? dm_addr : if_addr;
    w_is_write = w_grant_dm & dm_we;
  end

  // Only a 20-bit window of the byte address reaches the SRAM pins.
  assign w_unused_addr = ^w_addr;

  // Access sequencer: state, wait counter, strobes, bus enable, read data and acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_gnt_dm  <= 1'b0;
      r_last_dm <= 1'b0;
      r_wdata   <= 32'd0;
      r_drive   <= 1'b0;
      sram_addr <= 20'd0;
      sram_be_n <= 4'hF;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
    end else begin
      // acks are single-cycle pulses raised only on the edge entering DONE
      if_ack <= 1'b0;
      dm_ack <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // grant edge: capture everything the access needs so the
            // requester inputs are don't-care from here on
            r_gnt_dm  <= w_grant_dm;
            r_last_dm <= w_grant_dm;
            sram_addr <= w_addr[ADDR_LSB +: 20];
            sram_ce_n <= 1'b0;
            if (w_is_write) begin
              r_wdata   <= dm_wdata;
              sram_be_n <= dm_be_n;
              r_drive   <= 1'b1;
              r_state   <= S_WR_SETUP;
            end else begin
              sram_be_n <= 4'b0000;
              sram_oe_n <= 1'b0;
              r_cnt     <= c_rd_cnt;
              r_state   <= S_RD;
            end
          end
        end

        S_RD: begin
          if (r_cnt == 3'd0) begin
            // last read cycle: data has settled for WAIT_CYCLES+1 cycles
            if (r_gnt_dm) begin
              dm_rdata <= sram_data;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= sram_data;
              if_ack   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 4'hF;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        S_WR_SETUP: begin
          // address and data have been stable for one cycle; open the pulse
          sram_we_n <= 1'b0;
          r_cnt     <= c_pulse_cnt;
          r_state   <= S_WR_PULSE;
        end

        S_WR_PULSE: begin
          if (r_cnt == 3'd0) begin
            sram_we_n <= 1'b1;
            r_state   <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        S_WR_HOLD: begin
          // data and ce_n held one cycle past the rising we_n
          sram_ce_n <= 1'b1;
          sram_be_n <= 4'hF;
          r_drive   <= 1'b0;
          dm_ack    <= 1'b1;
          r_state   <= S_DONE;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_be_n <= 4'hF;
          r_drive   <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench for sram_arbiter with a behavioural
//            asynchronous SRAM per instance (WAIT_CYCLES = 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: WAIT_CYCLES = 1
  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [3:0]  a_dm_be_n, a_be_n;
  logic [19:0] a_addr;
  logic        a_ce_n, a_oe_n, a_we_n;
  wire  [31:0] a_data;

  // instance B: WAIT_CYCLES = 3
  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [3:0]  b_dm_be_n, b_be_n;
  logic [19:0] b_addr;
  logic        b_ce_n, b_oe_n, b_we_n;
  wire  [31:0] b_data;

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_LSB(2)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_be_n(a_dm_be_n), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
    .sram_data(a_data), .sram_addr(a_addr), .sram_be_n(a_be_n),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n)
  );

  sram_arbiter #(.WAIT_CYCLES(3), .ADDR_LSB(2)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_be_n(b_dm_be_n), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .sram_data(b_data), .sram_addr(b_addr), .sram_be_n(b_be_n),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n)
  );

  // --------------------------------------------------------------------------
  // Behavioural SRAMs: combinational read while ce_n/oe_n low and we_n high,
  // byte-masked write while ce_n/we_n low. An undriven bus floats to all ones.
  // --------------------------------------------------------------------------
  logic [31:0] a_mem [0:255];
  logic [31:0] b_mem [0:255];
  logic        pl_we = 1'b0;
  logic        pl_inst;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  assign a_data = (!a_ce_n && !a_oe_n && a_we_n) ? a_mem[a_addr[7:0]] : 32'bz;
  assign b_data = (!b_ce_n && !b_oe_n && b_we_n) ? b_mem[b_addr[7:0]] : 32'bz;
  pullup (a_data);
  pullup (b_data);

  always @(posedge clk) begin
    if (pl_we) begin
      if (pl_inst) b_mem[pl_idx] <= pl_val;
      else         a_mem[pl_idx] <= pl_val;
    end else begin
      if (!a_ce_n && !a_we_n)
        for (int i = 0; i < 4; i++)
          if (!a_be_n[i]) a_mem[a_addr[7:0]][8*i +: 8] <= a_data[8*i +: 8];
      if (!b_ce_n && !b_we_n)
        for (int i = 0; i < 4; i++)
          if (!b_be_n[i]) b_mem[b_addr[7:0]][8*i +: 8] <= b_data[8*i +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and checking helpers
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  port;     // {if_ack, dm_ack} pattern expected at completion
    bit          is_read;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int          cyc, ce_lo, oe_lo, we_lo;
  logic        acked;
  logic [1:0]  got_port;
  logic [31:0] got_data, bus_we;
  logic [19:0] seen_addr;
  logic [3:0]  seen_be;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit inst, input logic [7:0] idx, input logic [31:0] val);
    pl_inst = inst;
    pl_idx  = idx;
    pl_val  = val;
    pl_we   = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  // Counts negedges from the grant edge (first negedge = cycle 1) until an ack
  // appears, recording strobe activity along the way.
  task automatic wait_ack(input bit inst, input int limit);
    logic s_ce, s_oe, s_we, s_ia, s_da;
    cyc = 0; ce_lo = 0; oe_lo = 0; we_lo = 0;
    acked = 1'b0; got_port = 2'b00; got_data = '0; bus_we = '0;
    seen_addr = '0; seen_be = 4'hF;
    while (!acked && cyc < limit) begin
      @(negedge clk);
      cyc++;
      s_ce = inst ? b_ce_n   : a_ce_n;
      s_oe = inst ? b_oe_n   : a_oe_n;
      s_we = inst ? b_we_n   : a_we_n;
      s_ia = inst ? b_if_ack : a_if_ack;
      s_da = inst ? b_dm_ack : a_dm_ack;
      if (!s_ce) begin
        ce_lo++;
        seen_addr = inst ? b_addr : a_addr;
        seen_be   = inst ? b_be_n : a_be_n;
      end
      if (!s_oe) oe_lo++;
      if (!s_we) begin
        we_lo++;
        bus_we = inst ? b_data : a_data;
      end
      if (s_ia || s_da) begin
        acked    = 1'b1;
        got_port = {s_ia, s_da};
        got_data = s_ia ? (inst ? b_if_rdata : a_if_rdata)
                        : (inst ? b_dm_rdata : a_dm_rdata);
      end
    end
  endtask

  task automatic check_ack(input string tag, input int exp_cyc);
    exp_t e;
    check({tag, " ack_seen"}, 64'(acked), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    e = sb.pop_front();
    check({tag, " port"}, 64'(got_port), 64'(e.port));
    if (e.is_read) check({tag, " rdata"}, 64'(got_data), 64'(e.data));
  endtask

  // The cycle after DONE: ack gone, bus released.
  task automatic post_ack(input bit inst, input string tag);
    @(negedge clk);
    check({tag, " ack_1cyc"},
          64'(inst ? {b_if_ack, b_dm_ack} : {a_if_ack, a_dm_ack}), 64'd0);
    check({tag, " bus_off"}, 64'(inst ? b_data : a_data), 64'hFFFF_FFFF);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    a_if_req = 1'b0; a_if_addr = '0; a_dm_req = 1'b0; a_dm_we = 1'b0;
    a_dm_be_n = 4'hF; a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_be_n = 4'hF; b_dm_addr = '0; b_dm_wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // memory contents loaded while reset is held
    preload(1'b0, 8'd4,  32'h1234_5678);
    preload(1'b0, 8'd8,  32'h1122_3344);
    preload(1'b0, 8'd12, 32'hA1A1_0001);
    preload(1'b0, 8'd13, 32'hB2B2_0002);
    preload(1'b0, 8'd16, 32'h0000_0000);
    preload(1'b1, 8'd5,  32'h5555_AAAA);

    // ---- reset state with IF requesting ----
    @(negedge clk);
    a_if_req  = 1'b1;
    a_if_addr = 32'h8000_0010;
    @(negedge clk);
    check("rst strobes", 64'({a_ce_n, a_oe_n, a_we_n}), 64'b111);
    check("rst be_n", 64'(a_be_n), 64'hF);
    check("rst addr", 64'(a_addr), 64'd0);
    check("rst bus", 64'(a_data), 64'hFFFF_FFFF);
    check("rst acks", 64'({a_if_ack, a_dm_ack}), 64'd0);
    check("rst if_rdata", 64'(a_if_rdata), 64'd0);
    check("rst dm_rdata", 64'(a_dm_rdata), 64'd0);
    check("rst b strobes", 64'({b_ce_n, b_oe_n, b_we_n, b_be_n}), 64'h7F);

    // ---- IF read after release ----
    sb.push_back('{2'b10, 1'b1, 32'h1234_5678});
    rst = 1'b1;
    wait_ack(1'b0, 20);
    a_if_req = 1'b0;
    check_ack("if_rd", 3);
    check("if_rd ce_lo", 64'(ce_lo), 64'd2);
    check("if_rd oe_lo", 64'(oe_lo), 64'd2);
    check("if_rd addr", 64'(seen_addr), 64'h00004);
    check("if_rd be_n", 64'(seen_be), 64'h0);
    check("if_rd dm_rdata", 64'(a_dm_rdata), 64'd0);
    post_ack(1'b0, "if_rd");

    // ---- DM byte-masked write ----
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h8000_0020;
    a_dm_wdata = 32'hDEAD_BEEF; a_dm_be_n = 4'b1100;
    sb.push_back('{2'b01, 1'b0, 32'h0});
    wait_ack(1'b0, 20);
    a_dm_req = 1'b0;
    check_ack("dm_wr", 4);
    check("dm_wr ce_lo", 64'(ce_lo), 64'd3);
    check("dm_wr we_lo", 64'(we_lo), 64'd1);
    check("dm_wr oe_lo", 64'(oe_lo), 64'd0);
    check("dm_wr addr", 64'(seen_addr), 64'h00008);
    check("dm_wr be_n", 64'(seen_be), 64'hC);
    check("dm_wr bus", 64'(bus_we), 64'hDEAD_BEEF);
    check("dm_wr mem", 64'(a_mem[8]), 64'h1122_BEEF);
    check("dm_wr if_rdata", 64'(a_if_rdata), 64'h1234_5678);
    post_ack(1'b0, "dm_wr");

    // ---- both requesting continuously after reset: DM, IF, DM, IF ----
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a_dm_we = 1'b0; a_dm_addr = 32'h0000_0030; a_if_addr = 32'h0000_0034;
    a_dm_req = 1'b1; a_if_req = 1'b1;
    sb.push_back('{2'b01, 1'b1, 32'hA1A1_0001});
    sb.push_back('{2'b10, 1'b1, 32'hB2B2_0002});
    sb.push_back('{2'b01, 1'b1, 32'hA1A1_0001});
    sb.push_back('{2'b10, 1'b1, 32'hB2B2_0002});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, 20);
      if (k == 3) begin
        a_dm_req = 1'b0;
        a_if_req = 1'b0;
      end
      check_ack($sformatf("rr%0d", k), 3);
      post_ack(1'b0, $sformatf("rr%0d", k));
    end

    // ---- reset during WR_PULSE, then the re-presented write ----
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h8000_0040;
    a_dm_wdata = 32'hCAFE_F00D; a_dm_be_n = 4'b0000;
    @(negedge clk);
    check("wrs we_n", 64'({a_ce_n, a_we_n}), 64'b01);
    check("wrs bus", 64'(a_data), 64'hCAFE_F00D);
    @(negedge clk);
    check("wrp we_n", 64'(a_we_n), 64'd0);
    #1 rst = 1'b0;
    #1;
    check("abort strobes", 64'({a_ce_n, a_we_n}), 64'b11);
    check("abort bus", 64'(a_data), 64'hFFFF_FFFF);
    check("abort ack", 64'(a_dm_ack), 64'd0);
    @(negedge clk);
    check("abort ack2", 64'(a_dm_ack), 64'd0);
    check("abort mem", 64'(a_mem[16]), 64'd0);
    rst = 1'b1;
    sb.push_back('{2'b01, 1'b0, 32'h0});
    wait_ack(1'b0, 20);
    a_dm_req = 1'b0;
    check_ack("wr_rst", 4);
    check("wr_rst we_lo", 64'(we_lo), 64'd1);
    check("wr_rst mem", 64'(a_mem[16]), 64'hCAFE_F00D);
    post_ack(1'b0, "wr_rst");

    // ---- WAIT_CYCLES = 3 instance ----
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h0000_0014;
    sb.push_back('{2'b01, 1'b1, 32'h5555_AAAA});
    wait_ack(1'b1, 30);
    b_dm_req = 1'b0;
    check_ack("b_rd", 5);
    check("b_rd oe_lo", 64'(oe_lo), 64'd4);
    post_ack(1'b1, "b_rd");

    b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 32'h0000_0018;
    b_dm_wdata = 32'h0BAD_F00D; b_dm_be_n = 4'b0000;
    sb.push_back('{2'b01, 1'b0, 32'h0});
    wait_ack(1'b1, 30);
    b_dm_req = 1'b0;
    check_ack("b_wr", 6);
    check("b_wr we_lo", 64'(we_lo), 64'd3);
    post_ack(1'b1, "b_wr");

    b_dm_req = 1'b1; b_dm_we = 1'b0;
    sb.push_back('{2'b01, 1'b1, 32'h0BAD_F00D});
    wait_ack(1'b1, 30);
    b_dm_req = 1'b0;
    check_ack("b_rdback", 5);
    post_ack(1'b1, "b_rdback");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
